// File: rtl/control_hazard_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard/branch controller (slave).
// The datapath presents IR2..IR4 fields and flags every cycle; the controller answers combinationally.
interface control_hazard_if #(
   parameter int CNT_WIDTH = 16
);
   logic [3:0]           ir2_opcode;
   logic [1:0]           ir2_ra;
   logic [1:0]           ir2_rb;
   logic [3:0]           ir3_opcode;
   logic [1:0]           ir3_ra;
   logic [3:0]           ir4_opcode;
   logic [1:0]           ir4_ra;
   logic                 flag_z;
   logic                 flag_n;
   logic                 en_fetch;
   logic                 branch;
   logic                 ir2_hold;
   logic                 ir2_flush;
   logic                 ir3_bubble;
   logic                 halted;
   logic [CNT_WIDTH-1:0] stall_cnt;
   logic [CNT_WIDTH-1:0] taken_cnt;
   logic [1:0]           dbg_state;

   modport master (
      output ir2_opcode, ir2_ra, ir2_rb, ir3_opcode, ir3_ra, ir4_opcode, ir4_ra,
             flag_z, flag_n,
      input  en_fetch, branch, ir2_hold, ir2_flush, ir3_bubble, halted,
             stall_cnt, taken_cnt, dbg_state
   );

   modport slave (
      input  ir2_opcode, ir2_ra, ir2_rb, ir3_opcode, ir3_ra, ir4_opcode, ir4_ra,
             flag_z, flag_n,
      output en_fetch, branch, ir2_hold, ir2_flush, ir3_bubble, halted,
             stall_cnt, taken_cnt, dbg_state
   );
endinterface

// File: rtl/control_hazard.sv
// Hazard and branch-resolution controller for the 4-stage pipeline: stalls on RAW hazards,
// flushes on taken branches in IR3, drains and halts on stop, and keeps saturating counters.
module control_hazard #(
   parameter int CNT_WIDTH = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   control_hazard_if.slave    bus
);
   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'd0;
   localparam logic [3:0] OP_STOP  = 4'd1;
   localparam logic [3:0] OP_STORE = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd4;
   localparam logic [3:0] OP_BZ    = 4'd5;
   localparam logic [3:0] OP_SUB   = 4'd6;
   localparam logic [3:0] OP_NAND  = 4'd8;
   localparam logic [3:0] OP_BNZ   = 4'd9;
   localparam logic [3:0] OP_BPZ   = 4'd13;
   localparam logic [2:0] OP3_SHIFT = 3'd3;
   localparam logic [2:0] OP3_ORI   = 3'd7;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] stall_q, stall_d;
   logic [CNT_WIDTH-1:0] taken_q, taken_d;

   function automatic logic is_writer(input logic [3:0] op);
      return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) ||
             (op[2:0] == OP3_SHIFT) || (op[2:0] == OP3_ORI);
   endfunction

   // ori always targets R1 no matter what its ra field holds.
   function automatic logic [1:0] dest_of(input logic [3:0] op, input logic [1:0] ra);
      return (op[2:0] == OP3_ORI) ? 2'b01 : ra;
   endfunction

   logic       w3, w4;
   logic [1:0] d3, d4;
   logic       rd_a_en, rd_b_en;
   logic [1:0] rd_a;
   logic       dhaz, taken, ir3_stop;

   always_comb begin
      rd_a_en = 1'b0;
      rd_b_en = 1'b0;
      rd_a    = bus.ir2_ra;
      if (bus.ir2_opcode == OP_LOAD) begin
         rd_b_en = 1'b1;
      end else if ((bus.ir2_opcode == OP_STORE) || (bus.ir2_opcode == OP_ADD) ||
                   (bus.ir2_opcode == OP_SUB) || (bus.ir2_opcode == OP_NAND)) begin
         rd_a_en = 1'b1;
         rd_b_en = 1'b1;
      end else if (bus.ir2_opcode[2:0] == OP3_SHIFT) begin
         rd_a_en = 1'b1;
      end else if (bus.ir2_opcode[2:0] == OP3_ORI) begin
         rd_a_en = 1'b1;
         rd_a    = 2'b01;
      end
   end

   assign w3 = is_writer(bus.ir3_opcode);
   assign w4 = is_writer(bus.ir4_opcode);
   assign d3 = dest_of(bus.ir3_opcode, bus.ir3_ra);
   assign d4 = dest_of(bus.ir4_opcode, bus.ir4_ra);

   assign dhaz = (rd_a_en && ((w3 && rd_a == d3) || (w4 && rd_a == d4))) ||
                 (rd_b_en && ((w3 && bus.ir2_rb == d3) || (w4 && bus.ir2_rb == d4)));

   assign taken = ((bus.ir3_opcode == OP_BZ)  &&  bus.flag_z) ||
                  ((bus.ir3_opcode == OP_BNZ) && !bus.flag_z) ||
                  ((bus.ir3_opcode == OP_BPZ) && !bus.flag_n);

   assign ir3_stop = (bus.ir3_opcode == OP_STOP);

   always_comb begin
      state_d        = state_q;
      stall_d        = stall_q;
      taken_d        = taken_q;
      bus.en_fetch   = 1'b0;
      bus.branch     = 1'b0;
      bus.ir2_hold   = 1'b0;
      bus.ir2_flush  = 1'b0;
      bus.ir3_bubble = 1'b0;
      case (state_q)
         S_INIT: state_d = S_RUN;
         S_RUN: begin
            if (ir3_stop) begin
               bus.ir3_bubble = 1'b1;
               state_d        = S_DRAIN;
            end else if (taken) begin
               // A flushed IR2 cannot stall, so a coincident hazard is not counted.
               bus.branch     = 1'b1;
               bus.en_fetch   = 1'b1;
               bus.ir2_flush  = 1'b1;
               bus.ir3_bubble = 1'b1;
               if (taken_q != CNT_MAX) taken_d = taken_q + 1'b1;
            end else if (dhaz) begin
               bus.ir2_hold   = 1'b1;
               bus.ir3_bubble = 1'b1;
               if (stall_q != CNT_MAX) stall_d = stall_q + 1'b1;
            end else begin
               bus.en_fetch = 1'b1;
            end
         end
         S_DRAIN: begin
            bus.ir3_bubble = 1'b1;
            state_d        = S_HALT;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_INIT;
         stall_q <= '0;
         taken_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
         taken_q <= taken_d;
      end
   end

   assign bus.halted    = (state_q == S_HALT);
   assign bus.stall_cnt = stall_q;
   assign bus.taken_cnt = taken_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_control_hazard.sv
// Directed bench for control_hazard: table of single-cycle vectors plus reset and saturation sequences.
module tb_control_hazard;
   localparam int CW = 16;
   localparam logic [3:0] LOAD = 4'd0, STOP = 4'd1, STORE = 4'd2, SHIFT = 4'd3, ADD = 4'd4,
                          BZ = 4'd5, SUB = 4'd6, ORI = 4'd7, NAND = 4'd8, BNZ = 4'd9,
                          NOP = 4'd10, BPZ = 4'd13;

   logic clock;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   control_hazard_if #(.CNT_WIDTH(CW)) bus ();
   control_hazard #(.CNT_WIDTH(CW)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string      name;
      logic [3:0] i2op; logic [1:0] i2ra; logic [1:0] i2rb;
      logic [3:0] i3op; logic [1:0] i3ra;
      logic [3:0] i4op; logic [1:0] i4ra;
      logic       fz;   logic       fn;
      logic       en, br, hold, flush, bub, halt;
      logic [1:0] st;
      logic [CW-1:0] stall, taken;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] i2op, input logic [1:0] i2ra, input logic [1:0] i2rb,
                        input logic [3:0] i3op, input logic [1:0] i3ra,
                        input logic [3:0] i4op, input logic [1:0] i4ra,
                        input logic fz, input logic fn);
      bus.ir2_opcode = i2op; bus.ir2_ra = i2ra; bus.ir2_rb = i2rb;
      bus.ir3_opcode = i3op; bus.ir3_ra = i3ra;
      bus.ir4_opcode = i4op; bus.ir4_ra = i4ra;
      bus.flag_z = fz; bus.flag_n = fn;
   endtask

   task automatic check_ctrl(input string name, input logic en, input logic br, input logic hold,
                             input logic flush, input logic bub, input logic halt, input logic [1:0] st);
      check({name, ".state"}, 32'(bus.dbg_state), 32'(st));
      check({name, ".ctrl{en,br,hold,flush,bub,halt}"},
            32'({bus.en_fetch, bus.branch, bus.ir2_hold, bus.ir2_flush, bus.ir3_bubble, bus.halted}),
            32'({en, br, hold, flush, bub, halt}));
   endtask

   task automatic check_cnt(input string name, input logic [CW-1:0] stall, input logic [CW-1:0] taken);
      check({name, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(stall));
      check({name, ".taken_cnt"}, 32'(bus.taken_cnt), 32'(taken));
   endtask

   function automatic vec_t mk(input string name,
                               input logic [3:0] i2op, input logic [1:0] i2ra, input logic [1:0] i2rb,
                               input logic [3:0] i3op, input logic [1:0] i3ra,
                               input logic [3:0] i4op, input logic [1:0] i4ra,
                               input logic fz, input logic fn,
                               input logic en, input logic br, input logic hold, input logic flush,
                               input logic bub, input logic halt, input logic [1:0] st,
                               input int stall, input int taken);
      vec_t v;
      v.name = name; v.i2op = i2op; v.i2ra = i2ra; v.i2rb = i2rb;
      v.i3op = i3op; v.i3ra = i3ra; v.i4op = i4op; v.i4ra = i4ra; v.fz = fz; v.fn = fn;
      v.en = en; v.br = br; v.hold = hold; v.flush = flush; v.bub = bub; v.halt = halt; v.st = st;
      v.stall = CW'(stall); v.taken = CW'(taken);
      return v;
   endfunction

   // Inputs change after a rising edge, controls are sampled on the falling edge,
   // counters just after the next rising edge.
   task automatic apply(input vec_t v);
      drive(v.i2op, v.i2ra, v.i2rb, v.i3op, v.i3ra, v.i4op, v.i4ra, v.fz, v.fn);
      @(negedge clock);
      check_ctrl(v.name, v.en, v.br, v.hold, v.flush, v.bub, v.halt, v.st);
      @(posedge clock); #1;
      check_cnt(v.name, v.stall, v.taken);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      //            name        i2op  ra rb  i3op ra  i4op ra fz fn  en br ho fl bu ha st stall taken
      vecs.push_back(mk("idle",     NOP, 0, 0, NOP, 0, NOP, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk("haz_ir3",  NAND,1, 2, ADD, 2, NOP, 0, 0, 0,  0, 0, 1, 0, 1, 0, 1, 1, 0));
      vecs.push_back(mk("haz_ir4",  NAND,1, 2, NOP, 0, ADD, 2, 0, 0,  0, 0, 1, 0, 1, 0, 1, 2, 0));
      vecs.push_back(mk("haz_clr",  NAND,1, 2, NOP, 0, NOP, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 2, 0));
      vecs.push_back(mk("bz_t_haz", NAND,1, 2, BZ,  0, ADD, 2, 1, 0,  1, 1, 0, 1, 1, 0, 1, 2, 1));
      vecs.push_back(mk("bz_nt_haz",NAND,1, 2, BZ,  0, ADD, 2, 0, 0,  0, 0, 1, 0, 1, 0, 1, 3, 1));
      vecs.push_back(mk("bnz_t",    NOP, 0, 0, BNZ, 0, NOP, 0, 0, 0,  1, 1, 0, 1, 1, 0, 1, 3, 2));
      vecs.push_back(mk("bnz_nt",   NOP, 0, 0, BNZ, 0, NOP, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 3, 2));
      vecs.push_back(mk("bpz_t",    NOP, 0, 0, BPZ, 0, NOP, 0, 1, 0,  1, 1, 0, 1, 1, 0, 1, 3, 3));
      vecs.push_back(mk("bpz_nt",   NOP, 0, 0, BPZ, 0, NOP, 0, 0, 1,  1, 0, 0, 0, 0, 0, 1, 3, 3));
      vecs.push_back(mk("ori_ld1",  ORI, 0, 0, NOP, 0, LOAD,1, 0, 0,  0, 0, 1, 0, 1, 0, 1, 4, 3));
      vecs.push_back(mk("ori_ld3",  ORI, 0, 0, NOP, 0, LOAD,3, 0, 0,  1, 0, 0, 0, 0, 0, 1, 4, 3));
      vecs.push_back(mk("shf_ra",   SHIFT,3,0, SUB, 3, NOP, 0, 0, 0,  0, 0, 1, 0, 1, 0, 1, 5, 3));
      vecs.push_back(mk("shf_rb",   SHIFT,0,3, SUB, 3, NOP, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 5, 3));
      vecs.push_back(mk("ld_ori3",  LOAD,3, 1, ORI, 0, NOP, 0, 0, 0,  0, 0, 1, 0, 1, 0, 1, 6, 3));
      vecs.push_back(mk("ld_ori_no",LOAD,1, 0, ORI, 0, NOP, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 6, 3));
      vecs.push_back(mk("st_st",    STORE,2,0, STORE,2, NOP,0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 6, 3));
      vecs.push_back(mk("br_noread",BZ,  2, 2, NOP, 0, ADD, 2, 0, 0,  1, 0, 0, 0, 0, 0, 1, 6, 3));
      vecs.push_back(mk("add_rb4",  ADD, 0, 3, NOP, 0, NAND,3, 0, 0,  0, 0, 1, 0, 1, 0, 1, 7, 3));
      vecs.push_back(mk("stop_fl",  STOP,0, 0, BZ,  0, NOP, 0, 1, 0,  1, 1, 0, 1, 1, 0, 1, 7, 4));
      vecs.push_back(mk("stop_ir3", ADD, 2, 2, STOP,0, ADD, 2, 0, 0,  0, 0, 0, 0, 1, 0, 1, 7, 4));
      vecs.push_back(mk("drain",    NOP, 0, 0, BZ,  0, NOP, 0, 1, 0,  0, 0, 0, 0, 1, 0, 2, 7, 4));
      vecs.push_back(mk("halt1",    ADD, 2, 2, BZ,  0, ADD, 2, 1, 0,  0, 0, 0, 0, 0, 1, 3, 7, 4));
      vecs.push_back(mk("halt2",    NAND,1, 3, BNZ, 3, SUB, 1, 0, 1,  0, 0, 0, 0, 0, 1, 3, 7, 4));

      reset_n = 1'b0;
      drive(NOP, 0, 0, NOP, 0, NOP, 0, 1'b0, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      check_ctrl("reset", 0, 0, 0, 0, 0, 0, 2'd0);
      check_cnt("reset", '0, '0);
      reset_n = 1'b1;
      @(negedge clock);
      check_ctrl("init", 0, 0, 0, 0, 0, 0, 2'd0);
      @(posedge clock); #1;

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

      // Halt persists with arbitrary inputs.
      for (int i = 0; i < 8; i++) begin
         drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         @(posedge clock); #1;
      end
      check_ctrl("halt_sticky", 0, 0, 0, 0, 0, 1, 2'd3);
      check_cnt("halt_sticky", CW'(7), CW'(4));

      // Asynchronous reset mid-cycle.
      @(negedge clock); #2;
      reset_n = 1'b0;
      #1;
      check_ctrl("async_rst", 0, 0, 0, 0, 0, 0, 2'd0);
      check_cnt("async_rst", '0, '0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      drive(NOP, 0, 0, NOP, 0, NOP, 0, 1'b0, 1'b0);
      @(negedge clock);
      check_ctrl("post_rst_init", 0, 0, 0, 0, 0, 0, 2'd0);
      @(posedge clock); #1;

      // Saturation of the stall counter.
      drive(ADD, 1, 1, SUB, 1, NOP, 0, 1'b0, 1'b0);
      repeat ((1 << CW) - 2) @(posedge clock);
      #1;
      check_cnt("sat_near", CW'((1 << CW) - 2), '0);
      repeat (7) @(posedge clock);
      #1;
      check_cnt("sat_hold", '1, '0);
      @(negedge clock);
      check_ctrl("sat_ctrl", 0, 0, 1, 0, 1, 0, 2'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/control_hazard.md
Name: control_hazard

Overview:
- Pipeline hazard and branch-resolution controller for the 4-stage pipelined processor: IR1 fetch, IR2 decode/regread, IR3 execute, IR4 writeback.
- Produces the `branch` and `en_fetch` inputs consumed by the fetch-stage control, plus flush/bubble/hold controls for the IR2/IR3 pipeline registers.
- Tracks halt state and saturating performance counters.

Parameters:
- CNT_WIDTH, 16, width of the stall and taken-branch counters.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- ir2_opcode  in  4  opcode of instruction in IR2
- ir2_ra  in  2  IR2 register field R1 (bits 7:6)
- ir2_rb  in  2  IR2 register field R2 (bits 5:4)
- ir3_opcode  in  4  opcode in IR3
- ir3_ra  in  2  IR3 destination field
- ir4_opcode  in  4  opcode in IR4
- ir4_ra  in  2  IR4 destination field
- flag_z  in  1  zero flag valid for the IR3 branch (datapath-forwarded)
- flag_n  in  1  negative flag valid for the IR3 branch
- en_fetch  out  1  fetch enable to fetch control
- branch  out  1  select branch target for PC (pc_sel)
- ir2_hold  out  1  IR2 keeps its contents this cycle
- ir2_flush  out  1  IR2 loads nop instead of IR1
- ir3_bubble  out  1  IR3 loads nop instead of IR2
- halted  out  1  processor stopped; remains 1 until reset
- stall_cnt  out  CNT_WIDTH  data-stall cycle count
- taken_cnt  out  CNT_WIDTH  taken-branch count

Behaviour:
Opcode decode
- Full-opcode instructions: load=0, stop=1, store=2, add=4, bz=5, sub=6, nand=8, bnz=9, nop=10, bpz=13.
- 3-bit-opcode instructions, decoded on bits [2:0]: shift=3, ori=7.

Register writes
- Writers: load, add, sub, nand, shift write field ra.
- ori writes R1 (2'b01) regardless of field.

Register reads in IR2
- load: rb
- store/add/sub/nand: ra and rb
- shift: ra
- ori: R1
- Branches, nop and stop read no registers.

Data hazard
- `dhaz` = 1 when an IR2 read register equals the destination of a writer in IR3 or IR4.

Branch taken
- `taken` = 1 when IR3 holds:
  - bz with flag_z=1, or
  - bnz with flag_z=0, or
  - bpz with flag_n=0.

State machine (registered, reset → INIT)
- INIT
  - Outputs: en_fetch=0, all other control outputs 0.
  - Next state: RUN.
- RUN, priority order:
  1. IR3 opcode==stop → DRAIN. This cycle: en_fetch=0, ir3_bubble=1.
  2. taken → branch=1, en_fetch=1, ir2_flush=1, ir3_bubble=1, ir2_hold=0; taken_cnt++.
  3. dhaz → en_fetch=0, ir2_hold=1, ir3_bubble=1, branch=0; stall_cnt++.
  4. Otherwise → en_fetch=1, all other controls 0.
- DRAIN
  - Outputs: en_fetch=0, ir3_bubble=1.
  - Lasts one cycle, lets IR4 retire, then → HALT.
- HALT
  - Outputs: en_fetch=0, halted=1, all others 0.
  - Absorbing state; only reset_n leaves it.

Control outputs and counters
- branch, en_fetch, ir2_hold, ir2_flush and ir3_bubble are combinational from state and the IR inputs.
- halted is 1 exactly in HALT.
- Counters saturate at all-ones, with no wrap.

Boundary cases
- Taken branch and dhaz together → taken wins; no stall counted, because IR2 is flushed.
- Stop in IR2 while a taken branch is in IR3 → stop is flushed; no DRAIN.
- Non-taken branch → no effect.

Reset
- Reset asserted mid-operation → immediate INIT.
- Counters cleared, halted=0, all outputs 0.

Test Plan:
- Reset release, ir opcodes all nop → cycle 0: en_fetch=0. Cycle 1 onward: en_fetch=1, other controls 0, counters 0.
- IR3=add ra=2, IR2=nand ra=1 rb=2 → en_fetch=0, ir2_hold=1, ir3_bubble=1, stall_cnt=1. Next cycle IR3=nop, IR4=add ra=2 → stall continues, stall_cnt=2. Then IR4=nop → RUN normal.
- IR3=bz, flag_z=1, IR2 hazard also present → branch=1, ir2_flush=1, ir3_bubble=1, en_fetch=1, taken_cnt=1, stall_cnt unchanged. Same with flag_z=0 → branch=0.
- IR3=stop → en_fetch=0 for that cycle and the DRAIN cycle; halted=1 from the third cycle onward and stays 1 with arbitrary inputs. Pulse reset_n low → halted=0, INIT.
- Hold a dhaz condition for 2^CNT_WIDTH+5 cycles → stall_cnt sticks at all-ones.
- IR2=ori with IR4=load ra=1 → stall asserted. IR2=ori with IR4=load ra=3 → no stall.
